// File: rtl/lf_carrier_divider_if.sv
// Carrier timebase bus: run request and divisor in, divided clock and status out.
interface lf_carrier_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enable;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] pck_cnt;
    logic             pck_divclk;
    logic             period_start;
    logic             busy;
    logic [WIDTH-1:0] eff_div;

    // Configuration / consumer side
    modport master (
        output enable,
        output divisor,
        input  pck_cnt,
        input  pck_divclk,
        input  period_start,
        input  busy,
        input  eff_div
    );

    // Carrier generator side
    modport slave (
        input  enable,
        input  divisor,
        output pck_cnt,
        output pck_divclk,
        output period_start,
        output busy,
        output eff_div
    );
endinterface

// File: rtl/lf_carrier_divider.sv
// LF carrier timebase: glitch-free divided clock plus phase counter from pck0.
// Start/stop and divisor changes take effect only on whole-period boundaries.
module lf_carrier_divider #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MIN_DIV   = 15,
    parameter int unsigned RESET_DIV = 95
) (
    input  logic                pck0,
    input  logic                reset,
    lf_carrier_divider_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] eff_q;
    logic [WIDTH-1:0] eff_d;
    logic             divclk_q;
    logic             divclk_d;

    logic [WIDTH-1:0] clamped_div;
    logic             wrap;
    logic             end_of_period;
    logic             busy_c;
    logic             period_start_c;

    // Requested divisor floored so the counter always reaches MIN_DIV
    assign clamped_div = (bus.divisor < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : bus.divisor;

    // Half-period ends when the counter hits the active divisor; a full period
    // ends on the wrap that takes the divided clock from high to low
    assign wrap          = (cnt_q == eff_q);
    assign end_of_period = wrap & divclk_q;

    // State register
    always_ff @(posedge pck0 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: stopping is deferred until the end of a full period
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                state_d = bus.enable ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                state_d = bus.enable ? ST_RUN : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.enable) begin
                    state_d = ST_RUN;
                end else if (end_of_period) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        busy_c         = 1'b0;
        period_start_c = 1'b0;
        if (state_q != ST_IDLE) begin
            busy_c         = 1'b1;
            period_start_c = (cnt_q == '0) && !divclk_q;
        end
    end

    // Counter, divided clock and divisor reload; reload only on period boundaries
    always_comb begin
        cnt_d    = cnt_q;
        divclk_d = divclk_q;
        eff_d    = eff_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                divclk_d = 1'b0;
                if (state_d == ST_RUN) begin
                    eff_d = clamped_div;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (wrap) begin
                    cnt_d    = '0;
                    divclk_d = ~divclk_q;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
                if (end_of_period && (state_d == ST_RUN)) begin
                    eff_d = clamped_div;
                end
                if (state_d == ST_IDLE) begin
                    cnt_d    = '0;
                    divclk_d = 1'b0;
                end
            end
            default: begin
                cnt_d    = '0;
                divclk_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge pck0 or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            divclk_q <= 1'b0;
            eff_q    <= WIDTH'(RESET_DIV);
        end else begin
            cnt_q    <= cnt_d;
            divclk_q <= divclk_d;
            eff_q    <= eff_d;
        end
    end

    assign bus.pck_cnt      = cnt_q;
    assign bus.pck_divclk   = divclk_q;
    assign bus.eff_div      = eff_q;
    assign bus.busy         = busy_c;
    assign bus.period_start = period_start_c;

endmodule
